aes_inv_cipher_top: RTL and testbench

AES_INV_CIPHER_TOP -- requirements
Module: aes_inv_cipher_top

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_inv_sbox.sv | 11 +
 rtl/aes_key_expand_128.sv | 34 +++
 rtl/aes_inv_cipher_top.sv | 110 +++++++++++
 tb/tb_aes_inv_cipher_top.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, control states, S-box tables and the
// GF(2^8) arithmetic used by the inverse cipher datapath.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, KEXP, RUN} state_t;

  // Tables are indexed directly by the input byte: entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: bit i of c selects the b*2^i partial product.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);

  assign d = INV_SBOX[a];

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule: loads the cipher key on kld, then emits the next
// round key every cycle (round key 0 is visible the cycle after kld).
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [127:0] round_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_rot, n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign sub_rot = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
  assign n0 = w0 ^ sub_rot ^ {rcon, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (kld) begin
      {w0, w1, w2, w3} <= key;
      rcon             <= 8'h01;
    end else begin
      {w0, w1, w2, w3} <= {n0, n1, n2, n3};
      rcon             <= xtime(rcon);
    end
  end

  assign round_key = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryptor: buffers all round keys once per key load, then
// runs one inverse round per cycle from a shared datapath.
module aes_inv_cipher_top #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         key_ready,
  output logic         busy
);

  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state, nxt;
  logic         kld_acc, ld_acc;
  logic [3:0]   kcnt, rnd;
  logic [127:0] kb [0:NR];
  logic [127:0] text_in_r, st, round_key;
  logic [127:0] isr, isb, ark, imc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // kld outranks ld in IDLE; both strobes are ignored while a block is running.
  always_comb begin
    nxt     = state;
    kld_acc = kld && (state != RUN);
    ld_acc  = ld && !kld && (state == IDLE) && key_ready;
    unique case (state)
      IDLE: if (kld_acc) nxt = KEXP; else if (ld_acc) nxt = RUN;
      KEXP: if (kld_acc) nxt = KEXP; else if (kcnt == LAST) nxt = IDLE;
      RUN:  if (rnd == 4'd0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kcnt      <= 4'd0;
      rnd       <= 4'd0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      text_out  <= '0;
    end else begin
      done <= 1'b0;
      if (kld_acc) begin
        kcnt      <= 4'd0;
        key_ready <= 1'b0;
      end else if (state == KEXP) begin
        kcnt <= kcnt + 4'd1;
        if (kcnt == LAST) key_ready <= 1'b1;
      end
      if (ld_acc) begin
        busy <= 1'b1;
        rnd  <= LAST;
      end else if (state == RUN) begin
        if (rnd == 4'd0) begin
          text_out <= ark;
          done     <= 1'b1;
          busy     <= 1'b0;
        end else begin
          rnd <= rnd - 4'd1;
        end
      end
    end
  end

  // Key buffer and round state carry no reset; key_ready/state gate their use.
  always_ff @(posedge clk) begin
    if (!kld_acc && state == KEXP) kb[kcnt] <= round_key;
    if (ld_acc) text_in_r <= text_in;
    if (state == RUN) begin
      if (rnd == LAST)       st <= text_in_r ^ kb[NR];
      else if (rnd != 4'd0)  st <= imc;
    end
  end

  aes_key_expand_128 u_kexp (
    .clk       (clk),
    .kld       (kld_acc),
    .key       (key),
    .round_key (round_key)
  );

  // Byte (r,c) sits at index 4c+r, MSB first; row r rotates right by r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
      aes_inv_sbox u_sbox (
        .a (isr[127-8*(4*c+r) -: 8]),
        .d (isb[127-8*(4*c+r) -: 8])
      );
    end
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign ark = isb ^ kb[rnd];

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Directed bench for aes_inv_cipher_top: FIPS-197 vectors from a table plus
// hand-written handshake, reset and strobe-conflict sequences.
module tb_aes_inv_cipher_top;

  logic         clk = 1'b0;
  logic         rst, kld, ld, done, key_ready, busy;
  logic [127:0] key, text_in, text_out;
  int           n_checks = 0;
  int           n_bad = 0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] JUNK  = 128'hdeadbeef0badf00d123456789abcdef0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  aes_inv_cipher_top #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .kld       (kld),
    .key       (key),
    .ld        (ld),
    .text_in   (text_in),
    .text_out  (text_out),
    .done      (done),
    .key_ready (key_ready),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    tick();
    kld = 1'b0;
    checkOutput("key_ready_clear", key_ready, 1'b0);
    repeat (10) tick();
    checkOutput("key_ready_early", key_ready, 1'b0);
    tick();
    checkOutput("key_ready_rise", key_ready, 1'b1);
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input string name);
    int lat;
    lat = 0;
    ld = 1'b1;
    text_in = ct;
    tick();
    ld = 1'b0;
    text_in = JUNK;
    checkOutput({name, "_busy_set"}, busy, 1'b1);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (done) lat = i;
    end
    checkOutput({name, "_latency"}, lat, 11);
    checkOutput({name, "_text_out"}, text_out, pt);
    checkOutput({name, "_busy_clear"}, busy, 1'b0);
    tick();
    checkOutput({name, "_done_pulse"}, done, 1'b0);
    checkOutput({name, "_text_hold"}, text_out, pt);
  endtask

  task automatic applyStimulus(input vec_t v);
    load_key(v.key);
    decrypt(v.ct, v.pt, v.name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd, d1, d2;
    vecs[0] = '{name: "zero_key", key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};
    vecs[1] = '{name: "fips_b",   key: K_B,  ct: CT_B,  pt: PT_B};
    vecs[2] = '{name: "fips_c1",  key: K_C1, ct: CT_C1, pt: PT_C1};

    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    repeat (2) tick();
    checkOutput("rst_text_out", text_out, '0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_key_ready", key_ready, 1'b0);
    rst = 1'b1;
    tick();

    // ld with no key loaded must be dropped
    ld = 1'b1; text_in = CT_C1;
    tick();
    ld = 1'b0;
    checkOutput("nokey_busy", busy, 1'b0);
    nd = 0;
    repeat (13) begin tick(); if (done) nd++; end
    checkOutput("nokey_no_done", nd, 0);

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

    // ld while busy (E5) and at E11 ignored, ld at E12 accepted
    nd = 0; d1 = -1; d2 = -1;
    for (int e = 0; e < 30; e++) begin
      ld = (e == 0 || e == 5 || e == 11 || e == 12);
      text_in = (e == 0 || e == 12) ? CT_C1 : JUNK;
      tick();
      if (done) begin
        nd++;
        if (nd == 1) d1 = e; else d2 = e;
      end
    end
    ld = 1'b0;
    checkOutput("hs_done_count", nd, 2);
    checkOutput("hs_first_done", d1, 11);
    checkOutput("hs_second_done", d2, 23);
    checkOutput("hs_text_out", text_out, PT_C1);

    // reset in the middle of a decryption
    ld = 1'b1; text_in = CT_C1;
    tick();
    ld = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_text_out", text_out, '0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_key_ready", key_ready, 1'b0);
    nd = 0;
    repeat (2) begin tick(); if (done) nd++; end
    rst = 1'b1;
    repeat (14) begin tick(); if (done) nd++; end
    checkOutput("midrst_no_done", nd, 0);
    checkOutput("midrst_key_ready_low", key_ready, 1'b0);
    applyStimulus(vecs[2]);

    // kld and ld together: only the key load happens
    kld = 1'b1; key = K_B; ld = 1'b1; text_in = CT_C1;
    tick();
    kld = 1'b0; ld = 1'b0;
    checkOutput("both_busy", busy, 1'b0);
    checkOutput("both_text_hold", text_out, PT_C1);
    checkOutput("both_key_ready_clear", key_ready, 1'b0);
    nd = 0;
    repeat (11) begin tick(); if (done) nd++; end
    checkOutput("both_no_done", nd, 0);
    checkOutput("both_key_ready", key_ready, 1'b1);
    decrypt(CT_B, PT_B, "both_newkey");

    // kld during RUN is ignored
    d1 = -1;
    for (int e = 0; e < 15; e++) begin
      ld = (e == 0);
      text_in = CT_B;
      kld = (e == 3);
      key = K_C1;
      tick();
      if (done && d1 < 0) d1 = e;
    end
    ld = 1'b0; kld = 1'b0;
    checkOutput("runkld_done", d1, 11);
    checkOutput("runkld_text_out", text_out, PT_B);
    checkOutput("runkld_key_ready", key_ready, 1'b1);
    decrypt(CT_B, PT_B, "runkld_kept_key");
    applyStimulus(vecs[2]);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
